// File: rtl/reg_writeback_queue.sv
// Register write-back queue: buffers {reg, data} requests and issues at most one per cycle to the register file.
// Optional youngest-match forwarding is built when REG_WBQ_BYPASS_EN is defined; otherwise lookup outputs are tied to 0.
module reg_writeback_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$clog2(REG_COUNT)-1:0]  in_reg,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          out_enable,
  output logic                          reg_write,
  output logic [$clog2(REG_COUNT)-1:0]  write_reg,
  output logic [DATA_WIDTH-1:0]         write_data,
  input  logic [$clog2(REG_COUNT)-1:0]  lookup_reg,
  output logic                          lookup_hit,
  output logic [DATA_WIDTH-1:0]         lookup_data,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          empty
);

  localparam int REG_W = $clog2(REG_COUNT);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [REG_W-1:0]      reg_q  [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push;
  logic pop;

  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign in_ready  = (count_q < DEPTH_C);
  assign reg_write = !empty && out_enable;
  assign write_reg  = empty ? '0 : reg_q[rd_ptr_q];
  assign write_data = empty ? '0 : data_q[rd_ptr_q];

  // Requests to register 0 complete the handshake but are never stored.
  assign push = in_valid && in_ready && (in_reg != '0);
  assign pop  = reg_write;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10: begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        count_d  = count_q + CNT_W'(1);
      end
      2'b01: begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d  = count_q - CNT_W'(1);
      end
      2'b11: begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the entry storage is not reset; an entry is only ever observed when count marks it occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      reg_q[wr_ptr_q]  <= in_reg;
      data_q[wr_ptr_q] <= in_data;
    end
  end

`ifdef REG_WBQ_BYPASS_EN
  // Scan oldest to youngest so the last match seen is the youngest pending value.
  always_comb begin : lookup_scan
    logic [PTR_W-1:0] idx;
    idx         = '0;
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (lookup_reg != '0) && (reg_q[idx] == lookup_reg)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[idx];
      end
    end
  end
`else
  logic unused_lookup;
  assign unused_lookup = ^lookup_reg;
  assign lookup_hit    = 1'b0;
  assign lookup_data   = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench for reg_writeback_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_reg_writeback_queue;

  localparam int DW    = 32;
  localparam int RC    = 32;
  localparam int DEPTH = 4;
  localparam int RW    = $clog2(RC);
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_reg;
  logic [DW-1:0] in_data;
  logic          out_enable;
  logic          reg_write;
  logic [RW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic [RW-1:0] lookup_reg;
  logic          lookup_hit;
  logic [DW-1:0] lookup_data;
  logic [CW-1:0] count;
  logic          empty;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [RW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;

  ent_t model_q[$];

  reg_writeback_queue #(.DATA_WIDTH(DW), .REG_COUNT(RC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_reg      (in_reg),
    .in_data     (in_data),
    .out_enable  (out_enable),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .lookup_reg  (lookup_reg),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data),
    .count       (count),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model's view of the pending writes.
  task automatic compare_all();
    logic          exp_hit;
    logic [DW-1:0] exp_ldata;
    int            n;
    n         = model_q.size();
    exp_hit   = 1'b0;
    exp_ldata = '0;
`ifdef REG_WBQ_BYPASS_EN
    if (lookup_reg != 0)
      foreach (model_q[i])
        if (model_q[i].r == lookup_reg) begin
          exp_hit   = 1'b1;
          exp_ldata = model_q[i].d;
        end
`endif
    check("count",     64'(count),    64'(n));
    check("empty",     64'(empty),    64'(n == 0));
    check("in_ready",  64'(in_ready), 64'(n < DEPTH));
    check("reg_write", 64'(reg_write), 64'((n > 0) && out_enable));
    check("write_reg", 64'(write_reg), (n > 0) ? 64'(model_q[0].r) : 64'd0);
    check("write_data", 64'(write_data), (n > 0) ? 64'(model_q[0].d) : 64'd0);
    check("lookup_hit",  64'(lookup_hit),  64'(exp_hit));
    check("lookup_data", 64'(lookup_data), 64'(exp_ldata));
  endtask

  // One clock cycle: drive at negedge, check, then apply the edge's effect to the model.
  task automatic step(input logic v, input logic [RW-1:0] r, input logic [DW-1:0] d,
                      input logic oe, input logic [RW-1:0] lr);
    bit acc;
    bit wr;
    @(negedge clk);
    in_valid   = v;
    in_reg     = r;
    in_data    = d;
    out_enable = oe;
    lookup_reg = lr;
    #1;
    compare_all();
    acc = v && (model_q.size() < DEPTH);
    wr  = (model_q.size() > 0) && oe;
    if (wr) void'(model_q.pop_front());
    if (acc && (r != 0)) model_q.push_back('{r: r, d: d});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_reg_write"},  64'(reg_write),   64'd0);
    check({tag, "_write_reg"},  64'(write_reg),   64'd0);
    check({tag, "_write_data"}, 64'(write_data),  64'd0);
    check({tag, "_count"},      64'(count),       64'd0);
    check({tag, "_empty"},      64'(empty),       64'd1);
    check({tag, "_in_ready"},   64'(in_ready),    64'd1);
    check({tag, "_lookup_hit"}, 64'(lookup_hit),  64'd0);
    check({tag, "_lookup_data"}, 64'(lookup_data), 64'd0);
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_reg     = '0;
    in_data    = '0;
    out_enable = 1'b1;
    lookup_reg = 5'd5;
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0;

    // Basic path: one-cycle enqueue-to-write latency.
    step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd5);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
    check("basic_write_reg", 64'(write_reg), 64'd5);
    check("basic_write_data", 64'(write_data), 64'hDEAD_BEEF);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
    check("basic_count_after", 64'(count), 64'd0);

    // Fill and stall, a rejected 5th request, then in-order drain.
    for (int i = 1; i <= 4; i++)
      step(1'b1, RW'(i), DW'(i * 32'h11), 1'b0, 5'd2);
    step(1'b1, 5'd6, 32'h55, 1'b0, 5'd6);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_count", 64'(count), 64'd4);
    for (int i = 0; i < 5; i++)
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd6);

    // Register 0 is discarded.
    step(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0);
    step(1'b1, 5'd7, 32'h77, 1'b0, 5'd7);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    check("x0_drop_count", 64'(count), 64'd1);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7);

    // Youngest match wins for duplicate destinations.
    step(1'b1, 5'd9, 32'hA, 1'b0, 5'd9);
    step(1'b1, 5'd9, 32'hB, 1'b0, 5'd9);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd9);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd3);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd9);

    // Streaming at count 2 across pointer wrap.
    step(1'b1, 5'd10, 32'h100, 1'b0, 5'd10);
    step(1'b1, 5'd11, 32'h101, 1'b0, 5'd11);
    for (int i = 0; i < 10; i++)
      step(1'b1, RW'(12 + i), DW'(32'h200 + i), 1'b1, RW'(12 + i));
    check("stream_count", 64'(count), 64'd2);
    for (int i = 0; i < 3; i++)
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0);

    // Reset asserted between edges with three entries pending.
    for (int i = 0; i < 3; i++)
      step(1'b1, RW'(20 + i), DW'(32'h300 + i), 1'b0, 5'd20);
    @(negedge clk);
    in_valid   = 1'b0;
    out_enable = 1'b1;
    lookup_reg = 5'd20;
    reset      = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    model_q.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++)
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd21);

    // Random traffic with a narrow register range to exercise matches.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(9, 0) < 7), RW'($urandom_range(7, 0)), $urandom(),
           ($urandom_range(9, 0) < 6), RW'($urandom_range(7, 0)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_writeback_queue.md
# reg_writeback_queue

Write-side initiator for the single-write-port register file: buffers register write-back requests from execution and load units and issues them to the register file's write port at most one per cycle. Sits between the execute/memory stages and the register file. Absorbs bursts when the write port is unavailable. Optionally forwards the youngest pending value for a requested register so readers never see stale data.

## Interface
- `DATA_WIDTH`, 32, width of register data.
- `REG_COUNT`, 32, number of architectural registers; index width is `$clog2(REG_COUNT)`.
- `DEPTH`, 4, queue entries; power of two, ≥2.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  write-back request present.
- `in_ready`  out  1  queue can accept a request this cycle.
- `in_reg`  in  `$clog2(REG_COUNT)`  destination register of the request.
- `in_data`  in  `DATA_WIDTH`  value to write.
- `out_enable`  in  1  register file write port available this cycle.
- `reg_write`  out  1  write strobe to the register file.
- `write_reg`  out  `$clog2(REG_COUNT)`  destination index to the register file.
- `write_data`  out  `DATA_WIDTH`  data to the register file.
- `lookup_reg`  in  `$clog2(REG_COUNT)`  register being read by a consumer.
- `lookup_hit`  out  1  a pending entry targets `lookup_reg`.
- `lookup_data`  out  `DATA_WIDTH`  youngest pending value for `lookup_reg`.
- `count`  out  `$clog2(DEPTH)+1`  occupied entries.
- `empty`  out  1  `count == 0`.

## Operation
- Circular FIFO of `{reg, data}` entries, with a read pointer, a write pointer and an occupancy counter.
- Enqueue handshake: `in_valid && in_ready` at a rising edge.
- `in_ready = (count < DEPTH)`. No pass-through when full, even if a dequeue occurs in the same cycle.
- A handshaken request with `in_reg == 0` is consumed and discarded. It is not stored and `count` does not change.
- Dequeue: `reg_write = !empty && out_enable`. `write_reg`/`write_data` show the head entry, and are 0 when empty.
- The head pops on the same edge that the register file performs the write.
- Simultaneous enqueue and dequeue: `count` is unchanged and both pointers advance.
- Pointers wrap modulo `DEPTH`.
- Ordering: writes reach the register file strictly in acceptance order. Two entries to the same register both issue; the younger one lands last.
- Lookup (combinational):
  - Scan all valid entries; the youngest match with `lookup_reg`, by acceptance order, wins.
  - `lookup_reg == 0` never hits.
  - On a miss, `lookup_hit = 0` and `lookup_data = 0`.
  - The head entry being written this cycle still counts as a hit.
- Reset, asynchronous and taking effect immediately: pointers and count go to 0 and all entries are invalidated.
  - Outputs during and after reset: `in_ready = 1`, `reg_write = 0`, `write_reg = 0`, `write_data = 0`, `lookup_hit = 0`, `lookup_data = 0`, `count = 0`, `empty = 1`.
  - Pending entries are dropped and never written.

## Timing
- All output paths are combinational from state plus inputs: `reg_write` depends on `out_enable`, and `lookup_*` depends on `lookup_reg`.
- Enqueue-to-write latency: a request accepted at edge N is eligible as head in the cycle after N. It is written at edge N+1 at the earliest (queue empty, `out_enable` high).
- Throughput: one accept and one write per cycle sustained.
- `count` and `empty` reflect state after the most recent edge.
- `in_ready` changes only on clock edges or reset, never combinationally from `in_valid` or `out_enable`.
- Reset asserted mid-burst: no `reg_write` pulse in or after the reset cycle until new requests are accepted.

## Configuration
- `REG_WBQ_BYPASS_EN`:
  - Defined: lookup forwarding logic is built as described.
  - Undefined: `lookup_hit` and `lookup_data` are tied to 0, `lookup_reg` is ignored, and no comparators are synthesized. Queue behaviour is otherwise identical.

## Test plan
- Basic path: reset, then `out_enable = 1`, then enqueue `(x5, 0xDEADBEEF)`. Next cycle: `reg_write = 1`, `write_reg = 5`, `write_data = 0xDEADBEEF`, and `count` returns to 0 after that edge.
- Fill and stall: `out_enable = 0`, enqueue `x1..x4` with data `0x11..0x44`.
  - Expect `count = 4` and `in_ready = 0`. A 5th request is not accepted.
  - Raise `out_enable`: writes issue x1, x2, x3, x4 on consecutive cycles.
- x0 drop: enqueue `(x0, 0x1234)`, then `(x7, 0x77)`. Only one `reg_write` occurs (`x7`), and `count` never exceeds 1.
- Bypass youngest-wins (macro defined): with `out_enable = 0`, enqueue `(x9, 0xA)` then `(x9, 0xB)`.
  - `lookup_reg = 9` gives `hit = 1`, `data = 0xB`.
  - `lookup_reg = 3` gives `hit = 0`, `data = 0`.
  - With the macro undefined, both lookups give `hit = 0`.
- Simultaneous enqueue/dequeue at `count = 2` with wrap: streaming 10 requests with `out_enable = 1` keeps `count = 2` after the initial fill. Writes appear in order across pointer wrap.
- Reset mid-operation: with 3 entries pending, assert `reset` between edges.
  - Immediately: `reg_write = 0`, `count = 0`, `empty = 1`, `in_ready = 1`.
  - After release: no stale writes appear.
